// File: rtl/uart_boot_loader_pkg.sv
// Shared encodings and UART frame constants for the boot loader.
package uart_boot_loader_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        LD_LEN,
        LD_DATA,
        LD_DONE
    } ld_state_t;

endpackage

// File: rtl/uart_boot_loader_rx.sv
// 8N1 UART receiver: two-flop synchroniser plus mid-bit sampling FSM.
module uart_rx
    import uart_boot_loader_pkg::*;
#(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_frame_err
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic          s1, s2;
    rx_state_t     st;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sr;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= rxd;
            s2 <= s1;
        end
    end

    // Receive FSM; bits are sampled at their centre, outputs are one-cycle pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st           <= RX_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            sr           <= '0;
            rx_valid     <= 1'b0;
            rx_byte      <= '0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (st)
                RX_IDLE: begin
                    if (!s2) begin
                        st  <= RX_START;
                        cnt <= HALF;
                    end
                end
                RX_START: begin
                    if (cnt == '0) begin
                        if (s2) begin
                            st <= RX_IDLE;
                        end else begin
                            st      <= RX_DATA;
                            cnt     <= FULL;
                            bit_cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == '0) begin
                        sr  <= {s2, sr[7:1]};
                        cnt <= FULL;
                        if (bit_cnt == LAST_BIT) st <= RX_STOP;
                        else                     bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        st <= RX_IDLE;
                        if (s2) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= sr;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed image from the UART into BRAM, then releases the core.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rxd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              core_rstn
);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_frame_err;

    ld_state_t   st;
    logic [1:0]  byte_cnt;
    logic [23:0] shreg;     // bytes 0..2; byte 3 is taken straight from rx_byte
    logic [31:0] n;
    logic [31:0] word_idx;
    logic        last_wr;
    logic [31:0] word;

    assign word = {rx_byte, shreg};

    uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .clk          (clk),
        .rstn         (rstn),
        .rxd          (rxd),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rx_frame_err (rx_frame_err)
    );

    // Little-endian byte assembly; framing errors never reach here so byte_cnt holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (rx_valid && st != LD_DONE) begin
            byte_cnt <= byte_cnt + 1'b1;
            case (byte_cnt)
                2'd0:    shreg[7:0]   <= rx_byte;
                2'd1:    shreg[15:8]  <= rx_byte;
                2'd2:    shreg[23:16] <= rx_byte;
                default: ;
            endcase
        end
    end

    // Loader FSM: length word, then N data words, then release the core.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st        <= LD_LEN;
            n         <= '0;
            word_idx  <= '0;
            last_wr   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            core_rstn <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (rx_frame_err) frame_err <= 1'b1;
            case (st)
                LD_LEN: begin
                    if (rx_valid) begin
                        busy <= 1'b1;
                        if (byte_cnt == 2'd3) begin
                            n        <= word;
                            word_idx <= '0;
                            if (word == '0) begin
                                st        <= LD_DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                core_rstn <= 1'b1;
                            end else begin
                                st <= LD_DATA;
                            end
                        end
                    end
                end
                LD_DATA: begin
                    // Finish one cycle after the last write so done trails mem_we.
                    if (last_wr) begin
                        last_wr   <= 1'b0;
                        st        <= LD_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        core_rstn <= 1'b1;
                    end else if (rx_valid && byte_cnt == 2'd3) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_idx[ADDR_W-1:0];
                        mem_wdata <= word;
                        word_idx  <= word_idx + 1'b1;
                        last_wr   <= (word_idx == n - 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with CLK_PER_BIT=8, ADDR_W=20.
module tb_uart_boot_loader;

    localparam int CPB = 8;
    localparam int AW  = 20;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rxd = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy, done, frame_err, core_rstn;

    int checks = 0;
    int errors = 0;

    uart_boot_loader #(.CLK_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rxd       (rxd),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err),
        .core_rstn (core_rstn)
    );

    always #5 clk = ~clk;

    // Observed events, sampled on the falling edge.
    int            cyc = 0;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];
    int            wc[$];
    int            done_cyc = -1;
    int            busy_fall_cyc = -1;
    int            rxv_cyc = -1;
    logic          done_q = 1'b0, busy_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
        if (done && !done_q) done_cyc = cyc;
        if (!busy && busy_q) busy_fall_cyc = cyc;
        if (dut.rx_valid) rxv_cyc = cyc;
        done_q = done;
        busy_q = busy;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wa.delete(); wd.delete(); wc.delete();
        done_cyc = -1; busy_fall_cyc = -1; rxv_cyc = -1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        rstn = 1'b0;
        rxd  = 1'b1;
        repeat (3) @(posedge clk);
        clear_mon();
        rstn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // One 8N1 frame; a bad stop bit is held low for only 5 cycles so the
    // receiver's return to idle does not see the tail as a new start bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
        @(posedge clk);
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        rxd = stop_ok;
        repeat (stop_ok ? CPB : 5) @(posedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    typedef struct {
        logic [7:0] b;
        int         nwr;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t        vt[12];
    logic [7:0]  img[12];

    task automatic check_img_writes(input string tag);
        chk({tag, " nwr"}, wa.size(), 2);
        if (wa.size() == 2) begin
            chk({tag, " addr0"}, wa[0], 0);
            chk({tag, " data0"}, wd[0], 32'h1122_3344);
            chk({tag, " addr1"}, wa[1], 1);
            chk({tag, " data1"}, wd[1], 32'hDEAD_BEEF);
            chk({tag, " done_lat"}, done_cyc, wc[1] + 1);
            chk({tag, " busy_fall"}, busy_fall_cyc, done_cyc);
        end
    endtask

    initial begin
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 12; i++) begin
            vt[i].b    = img[i];
            vt[i].nwr  = (i >= 11) ? 2 : (i >= 7) ? 1 : 0;
            vt[i].busy = (i < 11);
            vt[i].done = (i == 11);
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst frame_err", frame_err, 0);
        chk("rst core_rstn", core_rstn, 0);
        do_reset();

        // Normal load, checked after every byte
        for (int i = 0; i < 12; i++) begin
            send_byte(vt[i].b);
            @(negedge clk);
            chk($sformatf("s1[%0d] nwr", i), wa.size(), vt[i].nwr);
            chk($sformatf("s1[%0d] busy", i), busy, vt[i].busy);
            chk($sformatf("s1[%0d] done", i), done, vt[i].done);
            chk($sformatf("s1[%0d] core_rstn", i), core_rstn, vt[i].done);
        end
        check_img_writes("s1");
        chk("s1 frame_err", frame_err, 0);

        // Post-done bytes are ignored
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        @(negedge clk);
        chk("post nwr", wa.size(), 2);
        chk("post done", done, 1);
        chk("post core_rstn", core_rstn, 1);

        // Zero length
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        @(negedge clk);
        chk("zero nwr", wa.size(), 0);
        chk("zero done", done, 1);
        chk("zero core_rstn", core_rstn, 1);
        chk("zero busy", busy, 0);
        chk("zero done_lat", done_cyc, rxv_cyc + 1);

        // Frame error mid-load
        do_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h22, 1'b0);
        @(negedge clk);
        chk("fe flag", frame_err, 1);
        chk("fe busy", busy, 1);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        @(negedge clk);
        chk("fe nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("fe addr", wa[0], 0);
            chk("fe data", wd[0], 32'h1122_3344);
        end
        chk("fe done", done, 1);
        chk("fe frame_err sticky", frame_err, 1);

        // Glitch shorter than half a bit
        do_reset();
        @(posedge clk);
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        rxd = 1'b1;
        repeat (4 * CPB) @(posedge clk);
        @(negedge clk);
        chk("glitch busy", busy, 0);
        chk("glitch frame_err", frame_err, 0);
        chk("glitch rx_valid", rxv_cyc, -1);

        // Mid-load reset, then a full resend
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(img[i]);
        @(negedge clk);
        chk("mid busy before", busy, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid mem_we", mem_we, 0);
        chk("mid mem_addr", mem_addr, 0);
        chk("mid mem_wdata", mem_wdata, 0);
        chk("mid busy", busy, 0);
        chk("mid done", done, 0);
        chk("mid frame_err", frame_err, 0);
        chk("mid core_rstn", core_rstn, 0);
        repeat (2) @(posedge clk);
        clear_mon();
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 12; i++) send_byte(img[i]);
        @(negedge clk);
        check_img_writes("mid");
        chk("mid done end", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
